// File: rtl/bpf_buf_sched_pkg.sv
// Shared definitions for the packet buffer ring.
// Buffer state encodings and a width helper.
package bpf_buf_sched_pkg;

  typedef enum logic [1:0] {
    BUF_FREE   = 2'd0,
    BUF_FILLED = 2'd1,
    BUF_ACC    = 2'd2,
    BUF_REJ    = 2'd3
  } buf_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bpf_buf_sched_ring_ptr.sv
// Wrapping ring index counter.
// Advances by one when adv is high.
module bpf_buf_sched_ring_ptr #(
  parameter int W   = 2,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // Step the index, wrapping after the last buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bpf_buf_sched.sv
// Three-party buffer ring: snooper fills, CPU
// filters, forwarder drains in arrival order.
module bpf_buf_sched
  import bpf_buf_sched_pkg::*;
#(
  parameter int N_BUFS     = 4,
  parameter int PLEN_WIDTH = 10,
  localparam int IDX_W     = clog2(N_BUFS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snooper_done,
  input  logic [PLEN_WIDTH-1:0] snooper_len,
  output logic                  ready_for_snooper,
  output logic [IDX_W-1:0]      snooper_buf,
  input  logic                  cpu_acc,
  input  logic                  cpu_rej,
  output logic                  ready_for_cpu,
  output logic [IDX_W-1:0]      cpu_buf,
  output logic [PLEN_WIDTH-1:0] len_to_cpu,
  input  logic                  forwarder_done,
  output logic                  ready_for_forwarder,
  output logic [IDX_W-1:0]      fwd_buf,
  output logic [PLEN_WIDTH-1:0] len_to_forwarder,
  output logic [IDX_W:0]        occupancy,
  output logic [31:0]           acc_count,
  output logic [31:0]           rej_count,
  output logic                  proto_err
);

  buf_state_t            st  [N_BUFS];
  logic [PLEN_WIDTH-1:0] len [N_BUFS];

  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] cpu_ptr;
  logic [IDX_W-1:0] fwd_ptr;

  logic snp_go;
  logic cpu_any;
  logic acc_go;
  logic rej_go;
  logic skip;
  logic fwd_go;
  logic fwd_free;
  logic err_now;

  assign snooper_buf = wr_ptr;
  assign cpu_buf     = cpu_ptr;
  assign fwd_buf     = fwd_ptr;

  assign ready_for_snooper   = (st[wr_ptr]  == BUF_FREE);
  assign ready_for_cpu       = (st[cpu_ptr] == BUF_FILLED);
  assign ready_for_forwarder = (st[fwd_ptr] == BUF_ACC);

  assign len_to_cpu       = len[cpu_ptr];
  assign len_to_forwarder = len[fwd_ptr];

  // Qualify each pulse against its owner's ready.
  always_comb begin
    cpu_any  = cpu_acc | cpu_rej;
    snp_go   = snooper_done & ready_for_snooper;
    rej_go   = cpu_rej & ready_for_cpu;
    acc_go   = cpu_acc & ~cpu_rej & ready_for_cpu;
    skip     = (st[fwd_ptr] == BUF_REJ);
    fwd_go   = forwarder_done & ready_for_forwarder;
    fwd_free = fwd_go | skip;
    err_now  = (snooper_done & ~ready_for_snooper)
             | (cpu_any & ~ready_for_cpu)
             | (cpu_acc & cpu_rej)
             | (forwarder_done & ~ready_for_forwarder);
  end

  bpf_buf_sched_ring_ptr #(.W(IDX_W), .MAX(N_BUFS)) u_wr (
    .clk (clk),
    .rst (rst),
    .adv (snp_go),
    .ptr (wr_ptr)
  );

  bpf_buf_sched_ring_ptr #(.W(IDX_W), .MAX(N_BUFS)) u_cpu (
    .clk (clk),
    .rst (rst),
    .adv (acc_go | rej_go),
    .ptr (cpu_ptr)
  );

  bpf_buf_sched_ring_ptr #(.W(IDX_W), .MAX(N_BUFS)) u_fwd (
    .clk (clk),
    .rst (rst),
    .adv (fwd_free),
    .ptr (fwd_ptr)
  );

  // Per-buffer ownership; the three writers never share a buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BUFS; i++) begin
        st[i]  <= BUF_FREE;
        len[i] <= '0;
      end
    end else begin
      if (snp_go) begin
        st[wr_ptr]  <= BUF_FILLED;
        len[wr_ptr] <= snooper_len;
      end
      if (rej_go) begin
        st[cpu_ptr] <= BUF_REJ;
      end else if (acc_go) begin
        st[cpu_ptr] <= BUF_ACC;
      end
      if (fwd_free) begin
        st[fwd_ptr] <= BUF_FREE;
      end
    end
  end

  // Occupancy: one in per fill, one out per release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (snp_go && !fwd_free) begin
      occupancy <= occupancy + 1'b1;
    end else if (fwd_free && !snp_go) begin
      occupancy <= occupancy - 1'b1;
    end
  end

  // Verdict counters and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_count <= '0;
      rej_count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (acc_go) acc_count <= acc_count + 32'd1;
      if (rej_go) rej_count <= rej_count + 32'd1;
      if (err_now) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpf_buf_sched.sv
// Bench for bpf_buf_sched: vector table,
// corner sequences and a randomized model run.
module tb_bpf_buf_sched;

  localparam int N  = 4;
  localparam int PW = 10;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          snooper_done = 1'b0;
  logic [PW-1:0] snooper_len = '0;
  logic          ready_for_snooper;
  logic [IW-1:0] snooper_buf;
  logic          cpu_acc = 1'b0;
  logic          cpu_rej = 1'b0;
  logic          ready_for_cpu;
  logic [IW-1:0] cpu_buf;
  logic [PW-1:0] len_to_cpu;
  logic          forwarder_done = 1'b0;
  logic          ready_for_forwarder;
  logic [IW-1:0] fwd_buf;
  logic [PW-1:0] len_to_forwarder;
  logic [IW:0]   occupancy;
  logic [31:0]   acc_count;
  logic [31:0]   rej_count;
  logic          proto_err;

  bpf_buf_sched #(.N_BUFS(N), .PLEN_WIDTH(PW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .snooper_done        (snooper_done),
    .snooper_len         (snooper_len),
    .ready_for_snooper   (ready_for_snooper),
    .snooper_buf         (snooper_buf),
    .cpu_acc             (cpu_acc),
    .cpu_rej             (cpu_rej),
    .ready_for_cpu       (ready_for_cpu),
    .cpu_buf             (cpu_buf),
    .len_to_cpu          (len_to_cpu),
    .forwarder_done      (forwarder_done),
    .ready_for_forwarder (ready_for_forwarder),
    .fwd_buf             (fwd_buf),
    .len_to_forwarder    (len_to_forwarder),
    .occupancy           (occupancy),
    .acc_count           (acc_count),
    .rej_count           (rej_count),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rs;
    logic          rc;
    logic          rf;
    logic [IW-1:0] sb;
    logic [IW-1:0] cb;
    logic [IW-1:0] fb;
    logic [IW:0]   occ;
    logic [PW-1:0] lc;
    logic [PW-1:0] lf;
    logic          pe;
  } obs_t;

  typedef struct {
    logic          snd;
    logic [PW-1:0] slen;
    logic          acc;
    logic          rej;
    logic          fd;
    obs_t          exp;
  } vec_t;

  int nv = 0;
  int nmis = 0;

  // reference model state
  int m_st [N];
  int m_len [N];
  int m_wr, m_cpu, m_fwd;
  int m_acc, m_rej;
  bit m_pe;

  function automatic obs_t ob(
    input logic rs, input logic rc, input logic rf,
    input int sb, input int cb, input int fb,
    input int occ, input int lc, input int lf,
    input logic pe);
    obs_t o;
    o.rs = rs; o.rc = rc; o.rf = rf;
    o.sb = IW'(sb); o.cb = IW'(cb); o.fb = IW'(fb);
    o.occ = (IW+1)'(occ);
    o.lc = PW'(lc); o.lf = PW'(lf);
    o.pe = pe;
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.rs = ready_for_snooper;
    o.rc = ready_for_cpu;
    o.rf = ready_for_forwarder;
    o.sb = snooper_buf;
    o.cb = cpu_buf;
    o.fb = fwd_buf;
    o.occ = occupancy;
    o.lc = len_to_cpu;
    o.lf = len_to_forwarder;
    o.pe = proto_err;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t e);
    obs_t a;
    a = get_obs();
    nv++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic check32(input string nm,
                         input logic [31:0] a,
                         input logic [31:0] e);
    nv++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    snooper_done = 1'b0;
    cpu_acc = 1'b0;
    cpu_rej = 1'b0;
    forwarder_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    snooper_done = 1'b0;
    cpu_acc = 1'b0;
    cpu_rej = 1'b0;
    forwarder_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic snd(input int l);
    snooper_done = 1'b1;
    snooper_len = PW'(l);
    tick();
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
    o.rs = (m_st[m_wr] == 0);
    o.rc = (m_st[m_cpu] == 1);
    o.rf = (m_st[m_fwd] == 2);
    o.sb = IW'(m_wr);
    o.cb = IW'(m_cpu);
    o.fb = IW'(m_fwd);
    o.occ = (IW+1)'(c);
    o.lc = PW'(m_len[m_cpu]);
    o.lf = PW'(m_len[m_fwd]);
    o.pe = m_pe;
    return o;
  endfunction

  task automatic model_step(input bit s, input int sl,
                            input bit a, input bit r,
                            input bit f);
    int w, c, fw;
    bit s_ok, c_ok, f_ok, skp;
    w = m_wr; c = m_cpu; fw = m_fwd;
    s_ok = s && m_st[w] == 0;
    c_ok = m_st[c] == 1;
    f_ok = f && m_st[fw] == 2;
    skp  = m_st[fw] == 3;
    if ((s && !s_ok) || ((a || r) && !c_ok) ||
        (a && r) || (f && !f_ok))
      m_pe = 1'b1;
    if (s_ok) begin
      m_st[w] = 1; m_len[w] = sl; m_wr = (w + 1) % N;
    end
    if (c_ok && r) begin
      m_st[c] = 3; m_rej++; m_cpu = (c + 1) % N;
    end else if (c_ok && a) begin
      m_st[c] = 2; m_acc++; m_cpu = (c + 1) % N;
    end
    if (f_ok || skp) begin
      m_st[fw] = 0; m_fwd = (fw + 1) % N;
    end
  endtask

  vec_t vt [9];

  initial begin
    vt[0] = '{1, 60, 0, 0, 0, ob(1,1,0,1,0,0,1,60,60,0)};
    vt[1] = '{1, 61, 0, 0, 0, ob(1,1,0,2,0,0,2,60,60,0)};
    vt[2] = '{1, 62, 0, 0, 0, ob(1,1,0,3,0,0,3,60,60,0)};
    vt[3] = '{0, 0,  0, 1, 0, ob(1,1,0,3,1,0,3,61,60,0)};
    vt[4] = '{0, 0,  0, 0, 0, ob(1,1,0,3,1,1,2,61,61,0)};
    vt[5] = '{0, 0,  1, 0, 0, ob(1,1,1,3,2,1,2,62,61,0)};
    vt[6] = '{0, 0,  0, 1, 0, ob(1,0,1,3,3,1,2,0,61,0)};
    vt[7] = '{0, 0,  0, 0, 1, ob(1,0,0,3,3,2,1,0,62,0)};
    vt[8] = '{0, 0,  0, 0, 0, ob(1,0,0,3,3,3,0,0,0,0)};

    do_reset();
    check("reset_state", ob(1,0,0,0,0,0,0,0,0,0));
    check32("reset_acc", acc_count, 32'd0);
    check32("reset_rej", rej_count, 32'd0);

    for (int i = 0; i < 9; i++) begin
      snooper_done   = vt[i].snd;
      snooper_len    = vt[i].slen;
      cpu_acc        = vt[i].acc;
      cpu_rej        = vt[i].rej;
      forwarder_done = vt[i].fd;
      tick();
      check($sformatf("vec%0d", i), vt[i].exp);
    end
    check32("tbl_acc", acc_count, 32'd1);
    check32("tbl_rej", rej_count, 32'd2);

    // ring full, then an overflow pulse
    do_reset();
    for (int i = 1; i <= 4; i++) snd(i);
    check("full", ob(0,1,0,0,0,0,4,1,1,0));
    snd(9);
    check("overflow", ob(0,1,0,0,0,0,4,1,1,1));

    // all three interfaces in one cycle
    do_reset();
    snd(5);
    snd(6);
    cpu_acc = 1'b1;
    tick();
    snooper_done = 1'b1;
    snooper_len = PW'(7);
    cpu_acc = 1'b1;
    forwarder_done = 1'b1;
    tick();
    check("same_cycle", ob(1,1,1,3,2,1,2,7,6,0));
    check32("same_cycle_acc", acc_count, 32'd2);

    // acc and rej together
    do_reset();
    snd(8);
    cpu_acc = 1'b1;
    cpu_rej = 1'b1;
    tick();
    check("acc_rej", ob(1,0,0,1,1,0,1,0,8,1));
    check32("acc_rej_rej", rej_count, 32'd1);
    check32("acc_rej_acc", acc_count, 32'd0);

    // asynchronous reset with buffers busy
    do_reset();
    snd(3);
    snd(4);
    cpu_acc = 1'b1;
    snooper_done = 1'b1;
    snooper_len = PW'(5);
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("async_rst", ob(1,0,0,0,0,0,0,0,0,0));
    check32("async_rst_acc", acc_count, 32'd0);
    #2;
    rst = 1'b1;

    // randomized run against the model
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_len[i] = 0;
    end
    m_wr = 0; m_cpu = 0; m_fwd = 0;
    m_acc = 0; m_rej = 0; m_pe = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      obs_t mo;
      bit s, a, r, f;
      int sl;
      mo = model_obs();
      check($sformatf("rnd%0d", k), mo);
      if (k % 50 == 0) begin
        check32("rnd_acc", acc_count, 32'(m_acc));
        check32("rnd_rej", rej_count, 32'(m_rej));
      end
      s = mo.rs ? ($urandom_range(0, 1) == 1)
                : ($urandom_range(0, 39) == 0);
      a = mo.rc ? ($urandom_range(0, 2) == 0)
                : ($urandom_range(0, 59) == 0);
      r = mo.rc ? ($urandom_range(0, 3) == 0)
                : ($urandom_range(0, 59) == 0);
      f = mo.rf ? ($urandom_range(0, 1) == 1)
                : ($urandom_range(0, 59) == 0);
      sl = int'($urandom_range(0, 1023));
      snooper_done = s;
      snooper_len = PW'(sl);
      cpu_acc = a;
      cpu_rej = r;
      forwarder_done = f;
      model_step(s, sl, a, r, f);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nv, nmis);
    $finish;
  end

endmodule

// File: doc/bpf_buf_sched.md
BPF_BUF_SCHED -- requirements
Module: bpf_buf_sched

Interface
REQ-001 SHALL take parameter N_BUFS, default 4; number of packet buffers in the ring; power of two, 2..16.
REQ-002 SHALL take parameter PLEN_WIDTH, default 10; width of a stored packet length in words.
REQ-003 SHALL derive localparam IDX_W = clog2(N_BUFS) as the buffer index width.
REQ-004 SHALL have one clock, clk, and one reset, rst; rst is asynchronous and active-low.
REQ-005 Ports, with name, direction, width and meaning:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- snooper_done  in  1  1-cycle pulse; current snooper buffer is complete.
- snooper_len  in  PLEN_WIDTH  packet length, sampled with snooper_done.
- ready_for_snooper  out  1  snooper buffer is free.
- snooper_buf  out  IDX_W  buffer the snooper writes.
- cpu_acc  in  1  1-cycle pulse; CPU accepts its buffer.
- cpu_rej  in  1  1-cycle pulse; CPU rejects its buffer.
- ready_for_cpu  out  1  CPU buffer holds an unfiltered packet.
- cpu_buf  out  IDX_W  buffer the CPU reads.
- len_to_cpu  out  PLEN_WIDTH  length of cpu_buf.
- forwarder_done  in  1  1-cycle pulse; forwarding of its buffer is complete.
- ready_for_forwarder  out  1  forwarder buffer is accepted.
- fwd_buf  out  IDX_W  buffer the forwarder reads.
- len_to_forwarder  out  PLEN_WIDTH  length of fwd_buf.
- occupancy  out  IDX_W+1  number of non-FREE buffers.
- acc_count  out  32  accepted packets, wrapping.
- rej_count  out  32  rejected packets, wrapping.
- proto_err  out  1  sticky flag; an ignored pulse arrived.

Function
REQ-006 SHALL keep a per-buffer state with the encodings FREE=0, FILLED=1, ACC=2, REJ=3, plus a per-buffer length register.
REQ-007 SHALL keep three IDX_W ring pointers, wr_ptr, cpu_ptr and fwd_ptr; each wraps from N_BUFS-1 to 0.
- snooper_buf = wr_ptr, cpu_buf = cpu_ptr, fwd_buf = fwd_ptr.
REQ-008 SHALL drive ready_for_snooper = (state[wr_ptr]==FREE), ready_for_cpu = (state[cpu_ptr]==FILLED) and ready_for_forwarder = (state[fwd_ptr]==ACC).
- All three are combinational from registers only; there is no input-to-output path.
REQ-009 On snooper_done with ready_for_snooper high, SHALL set state[wr_ptr]<=FILLED, len[wr_ptr]<=snooper_len and wr_ptr<=wr_ptr+1.
REQ-010 On cpu_acc with ready_for_cpu high, SHALL set state[cpu_ptr]<=ACC, advance cpu_ptr and increment acc_count.
REQ-011 On cpu_rej with ready_for_cpu high, SHALL set state[cpu_ptr]<=REJ, advance cpu_ptr and increment rej_count.
- cpu_acc and cpu_rej in the same cycle SHALL be treated as a reject and SHALL set proto_err.
REQ-012 On forwarder_done with ready_for_forwarder high, SHALL set state[fwd_ptr]<=FREE and advance fwd_ptr.
REQ-013 When state[fwd_ptr]==REJ, SHALL free that buffer and advance fwd_ptr on the next edge, without forwarder involvement.
- Skipping rejected buffers costs one cycle per buffer.
REQ-014 Buffers SHALL be forwarded strictly in arrival order; an ACC buffer never overtakes an earlier buffer.
REQ-015 Latency:
- snooper_done at edge t makes that buffer visible to the CPU at t+1, provided cpu_ptr points at it.
- cpu_acc at t raises ready_for_forwarder at t+1, provided fwd_ptr points at it.
REQ-016 Events on the three interfaces in the same cycle SHALL all take effect in that cycle; they always target distinct buffers.
REQ-017 A done, acc or rej pulse arriving while the matching ready is low SHALL be ignored and SHALL set proto_err.
REQ-018 occupancy SHALL be incremented on an accepted snooper_done and decremented on each transition to FREE.
- Both in one cycle leaves it unchanged; its range is 0..N_BUFS.
REQ-019 When all buffers are non-FREE, ready_for_snooper SHALL be low (ring full).
REQ-020 When the ring is empty, ready_for_cpu and ready_for_forwarder SHALL be low.

Reset
REQ-021 While rst is low, all of the following SHALL hold, asynchronously:
- every state is FREE and every length is 0;
- all pointers, occupancy, acc_count, rej_count and proto_err are 0;
- ready_for_snooper=1, ready_for_cpu=0, ready_for_forwarder=0.
REQ-022 Reset asserted mid-packet SHALL discard all buffer ownership; the ring restarts at buffer 0.

Structure
REQ-023 The state encodings and the clog2 function SHALL live in a shared definitions package used with packetmem and the CPU.
REQ-024 One sub-module is natural: ring_ptr, a wrapping IDX_W counter with an advance enable, instantiated three times.

Verification
REQ-025 Directed scenarios at N_BUFS=4:
- Reset, then snooper_done with len=60 -> next cycle ready_for_cpu=1, cpu_buf=0, len_to_cpu=60, occupancy=1.
- Four snooper_done pulses, no CPU activity -> ready_for_snooper=0, occupancy=4; a fifth pulse is ignored and sets proto_err=1.
- Buffers 0..2 filled; CPU gives rej, acc, rej -> buffer 0 auto-freed; fwd_buf=1 with ready_for_forwarder=1; after forwarder_done, buffer 2 is auto-freed; occupancy=0; rej_count=2, acc_count=1.
- Same-cycle snooper_done (buffer 2), cpu_acc (buffer 1) and forwarder_done (buffer 0) -> all three take effect, occupancy unchanged, pointers 3/2/1.
- cpu_acc and cpu_rej together -> buffer marked REJ, rej_count+1, proto_err=1.
- rst pulled low with 3 buffers busy -> all outputs at reset values immediately, without waiting for a clk edge.
